// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg
// Shared definitions for the round-robin arbitrating multiplexer.
//   RR_MUX_DEF_WIDTH : default data width per channel
//   RR_MUX_DEF_NCH   : default number of input channels
//   rr_state_t       : output-stage state; the encoding is the out_valid bit itself
package rr_mux_pkg;

  localparam int RR_MUX_DEF_WIDTH = 4;
  localparam int RR_MUX_DEF_NCH   = 4;

  // ST_FULL is deliberately 1 so the state register doubles as out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rr_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter: picks the first requester at or above the rotating
// pointer, wrapping from NCH-1 back to 0, and moves the pointer past the
// winner whenever a transfer is taken.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset, pointer returns to 0
//   req      : per-channel request vector
//   advance  : a transfer happens this cycle, so the pointer moves on
//   grant    : one-hot winner, zero when nothing requests
//   winner   : index of the winning channel (0 when nothing requests)
module rr_arbiter import rr_mux_pkg::*; #(
  parameter int NCH = RR_MUX_DEF_NCH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCH-1:0]         req,
  input  logic                   advance,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] winner
);

  localparam int PW = $clog2(NCH);

  logic [PW-1:0] ptr;
  int            idx;
  logic          found;

  // Scan NCH candidates starting at ptr. The index is folded back explicitly
  // rather than relying on PW-bit overflow, because NCH need not be a power
  // of two.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

  // The pointer lands on the channel just after the winner; the top channel
  // wraps to 0 so ptr never holds a value at or above NCH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      if (winner == PW'(NCH - 1)) ptr <= '0;
      else                        ptr <= winner + 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux.sv
// rr_mux
// N-channel round-robin arbitrating multiplexer with valid/ready on every
// input and on the output, and a single registered output stage.
// Optional feature macro: RR_MUX_ID_EN adds the out_id port and register that
// report which channel the held beat came from.
// Ports:
//   clk       : clock, rising edge
//   reset_n   : synchronous active-low reset
//   in_valid  : per-channel request, bit i is channel i
//   in_data   : channel i occupies [i*WIDTH +: WIDTH]
//   in_ready  : one-hot or zero, bit i means channel i transfers this cycle
//   out_valid : output register holds a beat
//   out_data  : the held beat
//   out_ready : consumer accepts the held beat
//   out_id    : source channel of the held beat (RR_MUX_ID_EN only)
module rr_mux import rr_mux_pkg::*; #(
  parameter int WIDTH = RR_MUX_DEF_WIDTH,
  parameter int NCH   = RR_MUX_DEF_NCH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready
`ifdef RR_MUX_ID_EN
  ,
  output logic [$clog2(NCH)-1:0] out_id
`endif
);

  localparam int IDW = $clog2(NCH);

  rr_state_t        state;
  rr_state_t        next_state;
  logic             load_en;
  logic             any_req;
  logic             transfer;
  logic [NCH-1:0]   grant;
  logic [IDW-1:0]   winner;
  logic [WIDTH-1:0] sel_data;

  // The output register may load when it is empty or its beat is leaving
  // this same cycle, which gives full throughput with no bubble. Folding
  // reset_n in keeps in_ready low throughout reset.
  assign any_req   = |in_valid;
  assign load_en   = reset_n && (!out_valid || out_ready);
  assign transfer  = load_en && any_req;
  assign in_ready  = load_en ? grant : '0;
  assign sel_data  = in_data[int'(winner)*WIDTH +: WIDTH];
  assign out_valid = (state == ST_FULL);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (in_valid),
    .advance (transfer),
    .grant   (grant),
    .winner  (winner)
  );

  // Next state: whenever the register may load it becomes FULL if someone
  // transfers and EMPTY otherwise; under backpressure it holds.
  always_comb begin
    next_state = state;
    if (load_en) begin
      next_state = any_req ? ST_FULL : ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_EMPTY;
    else          state <= next_state;
  end

  // Data is only written on a transfer, so an idle drain leaves the last
  // beat's value visible and backpressure holds it stable.
  always_ff @(posedge clk) begin
    if (!reset_n)      out_data <= '0;
    else if (transfer) out_data <= sel_data;
  end

`ifdef RR_MUX_ID_EN
  always_ff @(posedge clk) begin
    if (!reset_n)      out_id <= '0;
    else if (transfer) out_id <= winner;
  end
`endif

endmodule
